// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the lab calculator controller.
//   - datapath widths (accumulator, operand) and multiply iteration count
//   - opcode encodings OP_LOAD..OP_SHL
//   - controller FSM state encoding
//   - shl_sat: left shift that yields zero once the amount reaches ACC_W
package calc_pkg;

  localparam int ACC_W    = 24;
  localparam int OPR_W    = 8;
  localparam int MUL_ITER = 8;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // Shift amounts of ACC_W or more push every bit out of the accumulator.
  function automatic logic [ACC_W-1:0] shl_sat(input logic [ACC_W-1:0] a,
                                               input logic [4:0]       amt);
    if (amt >= 5'd24) begin
      shl_sat = '0;
    end else begin
      shl_sat = a << amt;
    end
  endfunction

endpackage

// File: rtl/calc_controller_btn_debounce.sv
// btn_debounce: conditions one raw active-low push-button.
//   clk, reset  : system clock, synchronous active-high reset
//   oneMsPulse  : 1 ms tick; the debounce counter only advances on it
//   btn_n       : raw button, active-low, asynchronous to clk
//   press       : registered one-cycle pulse on an accepted press (0->1)
module btn_debounce #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic oneMsPulse,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             lvl_s;

  // Synchronized button, inverted so that 1 means pressed.
  assign lvl_s = ~sync2_q;
  assign press = press_q;

  // Synchronizer, debounce counter and press-pulse generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to the released (high) raw level so no
      // spurious mismatch is seen right after reset.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (oneMsPulse) begin
        if (lvl_s != level_q) begin
          if (cnt_q == CNT_LAST) begin
            level_q <= lvl_s;
            cnt_q   <= '0;
            press_q <= lvl_s;  // only the released->pressed change pulses
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// calc_controller: sequencing controller for the lab calculator.
//   clk, reset  : system clock, synchronous active-high reset
//   oneMsPulse  : 1 ms tick for the button debouncers
//   SW          : operand switches
//   KEY_n       : raw buttons, active-low: [0] Enter, [1] Op, [2] Clear
//   OpReg       : last latched operand      ShowOpReg  : pulse on latch
//   OpCode      : selected operation        ShowOpCode : pulse on change
//   OpResult    : 24-bit accumulator        busy       : operation running
module calc_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             oneMsPulse,
  input  logic [7:0]       SW,
  input  logic [2:0]       KEY_n,
  output logic [7:0]       OpReg,
  output logic             ShowOpReg,
  output logic [2:0]       OpCode,
  output logic             ShowOpCode,
  output logic [23:0]      OpResult,
  output logic             busy
);

  logic enter_s, op_s, clear_s;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_enter (
    .clk(clk), .reset(reset), .oneMsPulse(oneMsPulse), .btn_n(KEY_n[0]), .press(enter_s));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_op (
    .clk(clk), .reset(reset), .oneMsPulse(oneMsPulse), .btn_n(KEY_n[1]), .press(op_s));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clear (
    .clk(clk), .reset(reset), .oneMsPulse(oneMsPulse), .btn_n(KEY_n[2]), .press(clear_s));

  state_e           state_q;
  logic [OPR_W-1:0] opreg_q;
  logic             showreg_q;
  logic [2:0]       opcode_q;
  logic             showcode_q;
  logic [ACC_W-1:0] result_q;
  logic             busy_q;
  logic [ACC_W-1:0] mcand_q;
  logic [OPR_W-1:0] mplier_q;
  logic [ACC_W-1:0] prod_q;
  logic [2:0]       iter_q;

  logic [ACC_W-1:0] opr_ext_s;
  logic [ACC_W-1:0] alu_s;
  logic [ACC_W-1:0] prod_next_s;

  assign opr_ext_s = {16'h0000, opreg_q};

  // Single-cycle ALU on the accumulator and the latched operand.
  always_comb begin
    alu_s = result_q;
    case (opcode_q)
      OP_LOAD: alu_s = opr_ext_s;
      OP_ADD:  alu_s = result_q + opr_ext_s;
      OP_SUB:  alu_s = result_q - opr_ext_s;
      OP_MUL:  alu_s = result_q;  // handled by the shift-add sequencer
      OP_AND:  alu_s = result_q & opr_ext_s;
      OP_OR:   alu_s = result_q | opr_ext_s;
      OP_XOR:  alu_s = result_q ^ opr_ext_s;
      OP_SHL:  alu_s = shl_sat(result_q, opreg_q[4:0]);
      default: alu_s = '0;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the current
  // multiplier LSB is set; the sum truncates to the accumulator width.
  always_comb begin
    if (mplier_q[0]) begin
      prod_next_s = prod_q + mcand_q;
    end else begin
      prod_next_s = prod_q;
    end
  end

  // Controller FSM with registered outputs; Clear overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      opreg_q    <= '0;
      showreg_q  <= 1'b0;
      opcode_q   <= OP_LOAD;
      showcode_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      iter_q     <= 3'd0;
    end else begin
      showreg_q  <= 1'b0;
      showcode_q <= 1'b0;
      if (clear_s) begin
        result_q <= '0;
        busy_q   <= 1'b0;
        state_q  <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Enter wins over a simultaneous Op press.
            if (enter_s) begin
              opreg_q   <= SW;
              showreg_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= ST_EXEC;
            end else if (op_s) begin
              opcode_q   <= opcode_q + 3'd1;
              showcode_q <= 1'b1;
            end
          end
          ST_EXEC: begin
            if (opcode_q == OP_MUL) begin
              mcand_q  <= result_q;
              mplier_q <= opreg_q;
              prod_q   <= '0;
              iter_q   <= 3'd0;
              state_q  <= ST_MUL;
            end else begin
              result_q <= alu_s;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          ST_MUL: begin
            prod_q   <= prod_next_s;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // Accumulator is written once, from the final step's sum.
            if (iter_q == 3'(MUL_ITER - 1)) begin
              result_q <= prod_next_s;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              iter_q <= iter_q + 3'd1;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign OpReg      = opreg_q;
  assign ShowOpReg  = showreg_q;
  assign OpCode     = opcode_q;
  assign ShowOpCode = showcode_q;
  assign OpResult   = result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with an expected-result scoreboard.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        oneMsPulse;
  logic [7:0]  SW;
  logic [2:0]  KEY_n;
  logic [7:0]  OpReg;
  logic        ShowOpReg;
  logic [2:0]  OpCode;
  logic        ShowOpCode;
  logic [23:0] OpResult;
  logic        busy;

  calc_controller #(.DEBOUNCE_MS(3)) dut (
    .clk(clk), .reset(reset), .oneMsPulse(oneMsPulse), .SW(SW), .KEY_n(KEY_n),
    .OpReg(OpReg), .ShowOpReg(ShowOpReg), .OpCode(OpCode), .ShowOpCode(ShowOpCode),
    .OpResult(OpResult), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] res;
    int          lat;   // cycles from ShowOpReg to busy low; 0 = not timed
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0, t_sreg = 0;
  int sreg_cnt = 0, scode_cnt = 0, busy_cnt = 0, res_changes = 0;
  logic prev_busy, prev_sreg, prev_scode;
  logic [23:0] prev_res;
  logic tick_fast = 1'b0;
  int tick_div = 0;
  logic [2:0] exp_opcode = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k);
    KEY_n[k] = 1'b0;
    step(30);
    KEY_n[k] = 1'b1;
    step(30);
  endtask

  task automatic op_press(input int n);
    for (int i = 0; i < n; i++) begin
      press(1);
      exp_opcode = exp_opcode + 3'd1;
    end
    check("opcode", {29'd0, OpCode}, {29'd0, exp_opcode});
  endtask

  task automatic push_exp(input logic [23:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic enter(input logic [7:0] sw, input logic [23:0] res, input int lat);
    SW = sw;
    push_exp(res, lat);
    press(0);
    check("opreg", {24'd0, OpReg}, {24'd0, sw});
  endtask

  task automatic clr_counts();
    sreg_cnt = 0;
    scode_cnt = 0;
    busy_cnt = 0;
    res_changes = 0;
  endtask

  // 1 ms tick: every 4th cycle, or every cycle while tick_fast is set.
  initial begin
    oneMsPulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div++;
      oneMsPulse = tick_fast | ((tick_div % 4) == 0);
    end
  end

  // Output monitor: pulse rules, activity counters, scoreboard pops.
  always @(negedge clk) begin
    cyc++;
    if (ShowOpReg) begin
      sreg_cnt++;
      t_sreg = cyc;
    end
    if (ShowOpCode) scode_cnt++;
    if (ShowOpReg || ShowOpCode) begin
      check("pulse_overlap", {31'd0, ShowOpReg & ShowOpCode}, 32'd0);
      check("pulse_width", {31'd0, (ShowOpReg & prev_sreg) | (ShowOpCode & prev_scode)}, 32'd0);
    end
    if (busy) busy_cnt++;
    if (OpResult !== prev_res) res_changes++;
    if (prev_busy && !busy) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        cur_e = exp_q.pop_front();
        check("opresult", {8'd0, OpResult}, {8'd0, cur_e.res});
        if (cur_e.lat != 0) check("latency", cyc - t_sreg, cur_e.lat);
      end
    end
    prev_busy  = busy;
    prev_sreg  = ShowOpReg;
    prev_scode = ShowOpCode;
    prev_res   = OpResult;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    SW = 8'h00;
    KEY_n = 3'b111;
    step(3);
    check("rst_opreg", {24'd0, OpReg}, 32'd0);
    check("rst_opcode", {29'd0, OpCode}, 32'd0);
    check("rst_opresult", {8'd0, OpResult}, 32'd0);
    check("rst_pulses", {30'd0, ShowOpReg, ShowOpCode}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step(5);

    // Debounce: two short bounces on Op, then a stable press and release.
    clr_counts();
    for (int b = 0; b < 2; b++) begin
      KEY_n[1] = 1'b0;
      step(6);
      KEY_n[1] = 1'b1;
      step(8);
    end
    check("bounce_no_pulse", scode_cnt, 0);
    KEY_n[1] = 1'b0;
    step(30);
    check("debounce_one_pulse", scode_cnt, 1);
    exp_opcode = 3'd1;
    check("debounce_opcode", {29'd0, OpCode}, {29'd0, exp_opcode});
    KEY_n[1] = 1'b1;
    step(30);
    check("release_no_pulse", scode_cnt, 1);
    op_press(7);   // eighth press overall wraps back to 0

    // LOAD / ADD / SUB / Clear.
    enter(8'hFF, 24'h0000FF, 1);
    op_press(1);
    enter(8'h01, 24'h000100, 1);
    op_press(1);
    enter(8'h02, 24'h0000FE, 1);
    press(2);
    check("clear_result", {8'd0, OpResult}, 32'd0);
    check("clear_keeps_opcode", {29'd0, OpCode}, 32'd2);
    check("clear_keeps_opreg", {24'd0, OpReg}, 32'h02);
    enter(8'h01, 24'hFFFFFF, 1);

    // Clear together with Enter in IDLE: clear only.
    clr_counts();
    SW = 8'h77;
    KEY_n[0] = 1'b0;
    KEY_n[2] = 1'b0;
    step(30);
    KEY_n = 3'b111;
    step(30);
    check("clr_enter_result", {8'd0, OpResult}, 32'd0);
    check("clr_enter_opreg", {24'd0, OpReg}, 32'h01);
    check("clr_enter_no_latch", sreg_cnt, 0);

    // Build acc = 0x001234 with LOAD, SHL, OR.
    op_press(6);
    enter(8'h12, 24'h000012, 1);
    op_press(7);
    enter(8'h08, 24'h001200, 1);
    op_press(6);
    enter(8'h34, 24'h001234, 1);
    op_press(6);

    // MUL 0x1234 * 0xFF with a second Enter landing while busy.
    tick_fast = 1'b1;
    step(4);
    clr_counts();
    SW = 8'hFF;
    push_exp(24'h1221CC, 9);
    KEY_n[0] = 1'b0;
    step(5);
    KEY_n[0] = 1'b1;
    step(3);
    KEY_n[0] = 1'b0;
    SW = 8'h55;
    step(20);
    check("mul_result", {8'd0, OpResult}, 32'h1221CC);
    check("mul_busy_cycles", busy_cnt, 9);
    check("mul_single_write", res_changes, 1);
    check("mul_enter_dropped", sreg_cnt, 1);
    check("mul_opreg", {24'd0, OpReg}, 32'hFF);
    KEY_n[0] = 1'b1;
    step(10);

    // Clear at T+4 of a MUL aborts it.
    clr_counts();
    SW = 8'h03;
    push_exp(24'h000000, 4);
    KEY_n[0] = 1'b0;
    step(4);
    KEY_n[2] = 1'b0;
    step(1);
    KEY_n[0] = 1'b1;
    step(25);
    check("abort_result", {8'd0, OpResult}, 32'd0);
    check("abort_busy_cycles", busy_cnt, 4);
    check("abort_single_write", res_changes, 1);
    KEY_n[2] = 1'b1;
    step(10);

    // Enter and Op pressed together: Enter only.
    clr_counts();
    SW = 8'h3C;
    push_exp(24'h000000, 9);
    KEY_n[0] = 1'b0;
    KEY_n[1] = 1'b0;
    step(20);
    check("both_showopreg", sreg_cnt, 1);
    check("both_no_showopcode", scode_cnt, 0);
    check("both_opcode", {29'd0, OpCode}, 32'd3);
    check("both_opreg", {24'd0, OpReg}, 32'h3C);
    KEY_n = 3'b111;
    step(10);
    tick_fast = 1'b0;
    step(10);

    // SHL boundaries.
    op_press(5);
    enter(8'h01, 24'h000001, 1);
    op_press(7);
    enter(8'h17, 24'h800000, 1);
    enter(8'h18, 24'h000000, 1);
    op_press(1);
    enter(8'h42, 24'h000042, 1);
    op_press(3);

    // Reset in the middle of a MUL.
    SW = 8'h05;
    push_exp(24'h000000, 0);
    KEY_n[0] = 1'b0;
    for (int n = 0; n < 40 && !ShowOpReg; n++) step(1);
    check("rstmul_started", {31'd0, ShowOpReg}, 32'd1);
    KEY_n[0] = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    check("rstmul_opreg", {24'd0, OpReg}, 32'd0);
    check("rstmul_opcode", {29'd0, OpCode}, 32'd0);
    check("rstmul_opresult", {8'd0, OpResult}, 32'd0);
    check("rstmul_pulses", {30'd0, ShowOpReg, ShowOpCode}, 32'd0);
    check("rstmul_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    exp_opcode = 3'd0;
    step(40);
    op_press(1);
    enter(8'h09, 24'h000009, 1);

    step(10);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
